hvsync_generator: RTL and testbench

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

---
 rtl/hvsync_pkg.sv | 22 ++
 rtl/hvsync_generator_if.sv | 13 +
 rtl/hvsync_generator_timing_counter.sv | 37 +++
 rtl/hvsync_generator.sv | 97 +++++++++
 tb/tb_hvsync_generator.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/hvsync_pkg.sv
// Default VGA 640x480@60 timing constants and the shared 10-bit position type.
package hvsync_pkg;

  typedef logic [9:0] pos_t;

  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  function automatic logic in_window(input pos_t p, input pos_t lo, input pos_t hi);
    return (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/hvsync_generator_if.sv
// Video timing bundle: sync strobes, visible-area flag and raster position.
interface hvsync_generator_if;
  import hvsync_pkg::*;

  logic hsync;
  logic vsync;
  logic display_on;
  pos_t hpos;
  pos_t vpos;

  modport master (output hsync, vsync, display_on, hpos, vpos);
  modport slave  (input  hsync, vsync, display_on, hpos, vpos);
endinterface

// File: rtl/hvsync_generator_timing_counter.sv
// Wrap-around position counter with clock-enable; exposes the next value so
// downstream decode can be registered without adding latency.
module timing_counter
  import hvsync_pkg::*;
#(
  parameter int unsigned TOTAL = H_TOTAL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output pos_t count_o,
  output pos_t next_o,
  output logic wrap_o
);

  localparam pos_t LAST = pos_t'(TOTAL - 1);

  pos_t count_q, count_d;

  assign wrap_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + pos_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/hvsync_generator.sv
// VGA raster timing generator. Define HVSYNC_PIXEL_DIV2_EN to derive the pixel
// tick from every second clk edge (e.g. 50 MHz clk -> 25 MHz pixels).
module hvsync_generator
  import hvsync_pkg::*;
#(
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam pos_t HS_START = pos_t'(H_DISPLAY + H_FRONT);
  localparam pos_t HS_END   = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam pos_t VS_START = pos_t'(V_DISPLAY + V_FRONT);
  localparam pos_t VS_END   = pos_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam pos_t H_VIS    = pos_t'(H_DISPLAY);
  localparam pos_t V_VIS    = pos_t'(V_DISPLAY);

  logic tick;

`ifdef HVSYNC_PIXEL_DIV2_EN
  logic phase_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase_q <= 1'b0;
    else        phase_q <= ~phase_q;
  end

  assign tick = phase_q;
`else
  assign tick = 1'b1;
`endif

  pos_t h_q, h_d, v_q, v_d;
  logic h_wrap, v_wrap_unused;

  timing_counter #(.TOTAL(H_TOTAL)) u_hcnt (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (tick),
    .count_o (h_q),
    .next_o  (h_d),
    .wrap_o  (h_wrap)
  );

  timing_counter #(.TOTAL(V_TOTAL)) u_vcnt (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (tick & h_wrap),
    .count_o (v_q),
    .next_o  (v_d),
    .wrap_o  (v_wrap_unused)
  );

  // Decoding the next position keeps the registered strobes aligned with hpos/vpos.
  logic hsync_q, hsync_d, vsync_q, vsync_d, disp_q, disp_d;

  always_comb begin
    hsync_d = ~in_window(h_d, HS_START, HS_END);
    vsync_d = ~in_window(v_d, VS_START, VS_END);
    disp_d  = (h_d < H_VIS) && (v_d < V_VIS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      disp_q  <= 1'b1;
    end else if (tick) begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      disp_q  <= disp_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = disp_q;
  assign hpos       = h_q;
  assign vpos       = v_q;

endmodule

// File: tb/tb_hvsync_generator.sv
// Self-checking bench for hvsync_generator; vertical timing is shortened so a
// whole frame fits in a short run, horizontal timing stays at the VGA default.
`timescale 1ns/1ps
module tb_hvsync_generator;
  import hvsync_pkg::*;

  localparam int unsigned HD = 640, HF = 16, HS = 96, HB = 48;
  localparam int unsigned VD = 20,  VF = 3,  VS = 2,  VB = 5;
  localparam int unsigned HT = HD + HF + HS + HB;
  localparam int unsigned VT = VD + VF + VS + VB;
`ifdef HVSYNC_PIXEL_DIV2_EN
  localparam int unsigned DIV = 2;
`else
  localparam int unsigned DIV = 1;
`endif

  logic clk;
  logic reset;
  hvsync_generator_if vid();

  hvsync_generator #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (vid.hsync),
    .vsync      (vid.vsync),
    .display_on (vid.display_on),
    .hpos       (vid.hpos),
    .vpos       (vid.vpos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned edges;
  int unsigned hs_low, vs_low, de_fall_h;
  logic        de_prev, de_fall_seen, stats_on;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the raster position is simply the tick count folded by the line/frame sizes.
  task automatic check_model(input string tag);
    int unsigned t, h, v;
    t = edges / DIV;
    h = t % HT;
    v = (t / HT) % VT;
    chk({tag, ".hpos"},  32'(vid.hpos), h);
    chk({tag, ".vpos"},  32'(vid.vpos), v);
    chk({tag, ".hsync"}, 32'(vid.hsync), (h >= HD + HF && h < HD + HF + HS) ? 0 : 1);
    chk({tag, ".vsync"}, 32'(vid.vsync), (v >= VD + VF && v < VD + VF + VS) ? 0 : 1);
    chk({tag, ".de"},    32'(vid.display_on), (h < HD && v < VD) ? 1 : 0);
  endtask

  task automatic observe();
    int unsigned t;
    t = edges / DIV;
    if (t < HT) begin
      if (!vid.hsync) hs_low++;
      if (de_prev && !vid.display_on && !de_fall_seen) begin
        de_fall_h    = 32'(vid.hpos);
        de_fall_seen = 1'b1;
      end
      de_prev = vid.display_on;
    end
    if (t < HT * VT && !vid.vsync) vs_low++;
  endtask

  task automatic run_ticks(input int unsigned n);
    repeat (n * DIV) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      check_model("run");
      if (stats_on && (edges % DIV == 0)) observe();
    end
  endtask

  // Called at a falling edge: reset lands mid-cycle, well away from any rising edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    edges = 0;
    #1 check_model("async_rst");
    repeat (2) begin
      @(negedge clk);
      check_model("rst_hold");
    end
    reset = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; edges = 0;
    hs_low = 0; vs_low = 0; de_fall_h = 0;
    de_prev = 1'b1; de_fall_seen = 1'b0; stats_on = 1'b0;
    reset = 1'b0;

    #12 check_model("reset");
    repeat (2) begin
      @(negedge clk);
      check_model("reset_hold");
    end

    stats_on = 1'b1;
    reset    = 1'b1;
    run_ticks(1);
    chk("first_tick.hpos", 32'(vid.hpos), 1);
    run_ticks(HT - 2);
    chk("line_end.hpos", 32'(vid.hpos), HT - 1);
    chk("line_end.vpos", 32'(vid.vpos), 0);
    run_ticks(1);
    chk("line_wrap.hpos", 32'(vid.hpos), 0);
    chk("line_wrap.vpos", 32'(vid.vpos), 1);

    run_ticks(HT * VT - HT - 1);
    chk("corner.hpos", 32'(vid.hpos), HT - 1);
    chk("corner.vpos", 32'(vid.vpos), VT - 1);
    run_ticks(1);
    chk("frame_wrap.hpos",  32'(vid.hpos), 0);
    chk("frame_wrap.vpos",  32'(vid.vpos), 0);
    chk("frame_wrap.de",    32'(vid.display_on), 1);
    chk("frame_wrap.hsync", 32'(vid.hsync), 1);
    chk("frame_wrap.vsync", 32'(vid.vsync), 1);
    stats_on = 1'b0;

    chk("hsync_low_ticks", hs_low, HS);
    chk("vsync_low_ticks", vs_low, VS * HT);
    chk("de_fall_hpos",    de_fall_h, HD);

    run_ticks(900);
    run_ticks(12 * HT + 300 - 900);
    chk("pre_rst.hpos", 32'(vid.hpos), 300);
    chk("pre_rst.vpos", 32'(vid.vpos), 12);
    async_reset();
    run_ticks(1);
    chk("restart.hpos", 32'(vid.hpos), 1);
    chk("restart.vpos", 32'(vid.vpos), 0);
    run_ticks(50);

    run_ticks($urandom_range(1, 4000));
    async_reset();
    run_ticks(800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
